// File: rtl/spart_line_echo_driver_pkg.sv
// Shared constants, FSM state encoding and baud-divisor lookup for the spart
// line-echo bus master.
package spart_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'b00;
  localparam logic [1:0] ADDR_STATUS = 2'b01;
  localparam logic [1:0] ADDR_DB_LO  = 2'b10;
  localparam logic [1:0] ADDR_DB_HI  = 2'b11;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  typedef enum logic [3:0] {
    INIT_LO, INIT_HI, IDLE, RD, STORE,
    FLUSH_WAIT, TX_WR, HOLD,
    LF_WAIT, LF_WR, LF_HOLD, DONE
  } state_t;

  // Divisors for a 50 MHz system clock.
  function automatic logic [15:0] divisor(input logic [1:0] br_cfg);
    case (br_cfg)
      2'b00:   divisor = 16'd650;
      2'b01:   divisor = 16'd325;
      2'b10:   divisor = 16'd162;
      default: divisor = 16'd81;
    endcase
  endfunction

endpackage

// File: rtl/spart_line_echo_driver_line_fifo.sv
// Line buffer: power-of-two FIFO with combinational head and occupancy count.
module line_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    cnt_q;

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;
  assign dout  = mem_q[rd_q];

  always_ff @(posedge clk) begin
    if (push && !full) mem_q[wr_q] <= din;
  end

  // Pointers wrap naturally at AW bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (push && !full) begin
      wr_q  <= wr_q + 1'b1;
      cnt_q <= cnt_q + 1'b1;
    end else if (pop && !empty) begin
      rd_q  <= rd_q + 1'b1;
      cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/spart_line_echo_driver.sv
// Spart bus master: programs the baud divisor, buffers received bytes into a
// line and echoes the whole line on CR or full buffer (optionally adding LF).
module spart_line_echo_driver
  import spart_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int APPEND_LF   = 1,
  parameter int TBR_HOLDOFF = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] br_cfg,
  input  logic       rda,
  input  logic       tbr,
  output logic       iocs,
  output logic       iorw,
  output logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  output logic       echo_busy,
  output logic [7:0] line_count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int HW = (TBR_HOLDOFF > 1) ? $clog2(TBR_HOLDOFF) : 1;
  localparam logic [HW-1:0] HOLD_INIT = HW'(TBR_HOLDOFF - 1);

  state_t        state_q, state_d;
  logic [1:0]    br_cfg_q, cfg_prog_q, cfg_prog_d;
  logic [7:0]    rx_q, lc_q, lc_d, wdata;
  logic [HW-1:0] hold_q, hold_d;
  logic          lf_q, lf_d, busy_q, busy_d, gap_q;
  logic          acc, rw, push, pop;
  logic [1:0]    addr;
  logic [15:0]   div_new, div_prog;
  logic [7:0]    f_dout;
  logic          f_full, f_empty;
  logic [CW-1:0] f_count;

  line_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .din(rx_q), .pop(pop),
    .dout(f_dout), .full(f_full), .empty(f_empty), .count(f_count)
  );

  assign div_new  = divisor(br_cfg_q);
  assign div_prog = divisor(cfg_prog_q);

  // rst gates the strobes so the bus is released in the cycle rst rises.
  assign iocs       = acc & ~rst;
  assign iorw       = rw | rst;
  assign ioaddr     = rst ? ADDR_DATA : addr;
  assign databus    = (iocs && !iorw) ? wdata : 8'hzz;
  assign echo_busy  = busy_q;
  assign line_count = lc_q;

  always_ff @(posedge clk) br_cfg_q <= br_cfg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= INIT_LO;
      cfg_prog_q <= 2'b00;
      rx_q       <= 8'h00;
      lc_q       <= 8'h00;
      hold_q     <= '0;
      lf_q       <= 1'b0;
      busy_q     <= 1'b0;
      gap_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cfg_prog_q <= cfg_prog_d;
      lc_q       <= lc_d;
      hold_q     <= hold_d;
      lf_q       <= lf_d;
      busy_q     <= busy_d;
      gap_q      <= acc;
      if (state_q == RD && !gap_q) rx_q <= databus;
    end
  end

  // Any access state stalls one cycle if the previous cycle was an access.
  always_comb begin
    state_d    = state_q;
    cfg_prog_d = cfg_prog_q;
    lc_d       = lc_q;
    hold_d     = hold_q;
    lf_d       = lf_q;
    busy_d     = busy_q;
    acc        = 1'b0;
    rw         = 1'b1;
    addr       = ADDR_DATA;
    wdata      = 8'h00;
    push       = 1'b0;
    pop        = 1'b0;
    case (state_q)
      INIT_LO: if (!gap_q) begin
        acc = 1'b1; rw = 1'b0; addr = ADDR_DB_LO; wdata = div_new[7:0];
        cfg_prog_d = br_cfg_q;
        state_d = INIT_HI;
      end
      INIT_HI: if (!gap_q) begin
        acc = 1'b1; rw = 1'b0; addr = ADDR_DB_HI; wdata = div_prog[15:8];
        state_d = IDLE;
      end
      IDLE: begin
        if (f_empty && br_cfg_q != cfg_prog_q) state_d = INIT_LO;
        else if (rda)                          state_d = RD;
      end
      RD: if (!gap_q) begin
        acc = 1'b1;
        state_d = STORE;
      end
      STORE: begin
        push = ~f_full;
        if (rx_q == ASCII_CR || f_count == CW'(DEPTH - 1)) begin
          lf_d    = (rx_q == ASCII_CR) && (APPEND_LF != 0);
          state_d = FLUSH_WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      FLUSH_WAIT: begin
        if (!f_empty) begin
          if (tbr) state_d = TX_WR;
        end else if (lf_q) begin
          state_d = LF_WAIT;
        end else begin
          state_d = DONE;
        end
      end
      TX_WR: if (!gap_q) begin
        acc = 1'b1; rw = 1'b0; wdata = f_dout;
        pop = 1'b1; busy_d = 1'b1; hold_d = HOLD_INIT;
        state_d = HOLD;
      end
      HOLD, LF_HOLD: begin
        if (hold_q == '0) state_d = FLUSH_WAIT;
        else              hold_d  = hold_q - 1'b1;
      end
      LF_WAIT: if (tbr) state_d = LF_WR;
      LF_WR: if (!gap_q) begin
        acc = 1'b1; rw = 1'b0; wdata = ASCII_LF;
        lf_d = 1'b0; busy_d = 1'b1; hold_d = HOLD_INIT;
        state_d = LF_HOLD;
      end
      DONE: if (tbr) begin
        lc_d    = lc_q + 8'd1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = INIT_LO;
    endcase
  end

endmodule

// File: tb/tb_spart_line_echo_driver.sv
// Directed bench: two drivers (with and without LF) each on a behavioural spart
// that queues RX bytes for the driver and logs every bus write.
module tb_spart_line_echo_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] br_cfg = 2'b01;
  int tests = 0;
  int fails = 0;

  logic [7:0] rx_buf [2][64];
  int         rx_wr  [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_d
    logic       iocs, iorw, echo_busy;
    logic [1:0] ioaddr;
    logic [7:0] line_count;
    wire  [7:0] databus;
    wire        tbr, rda;
    int         rx_rd = 0;
    logic       rd_seen = 1'b0;
    logic [7:0] tx_log [64];
    int         tx_n = 0;
    logic [1:0] w_addr [64];
    logic [7:0] w_data [64];
    int         wn = 0;
    int         tb_cnt = 0;
    logic       prev_iocs = 1'b0;
    int         viol = 0;

    assign tbr     = (tb_cnt == 0);
    assign rda     = (rx_rd != rx_wr[g]);
    assign databus = (iocs && iorw && ioaddr == 2'b00) ? rx_buf[g][rx_rd[5:0]] : 8'hzz;

    spart_line_echo_driver #(.DEPTH(16), .APPEND_LF(g == 0 ? 1 : 0), .TBR_HOLDOFF(4)) dut (
      .clk(clk), .rst(rst), .br_cfg(br_cfg), .rda(rda), .tbr(tbr),
      .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr), .databus(databus),
      .echo_busy(echo_busy), .line_count(line_count)
    );

    always @(negedge clk) begin
      if (rd_seen) rx_rd <= rx_rd + 1;
      rd_seen <= iocs && iorw && ioaddr == 2'b00;
      if (tb_cnt > 0) tb_cnt <= tb_cnt - 1;
      if (iocs && !iorw) begin
        w_addr[wn[5:0]] <= ioaddr;
        w_data[wn[5:0]] <= databus;
        wn <= wn + 1;
        if (ioaddr == 2'b00) begin
          tx_log[tx_n[5:0]] <= databus;
          tx_n   <= tx_n + 1;
          tb_cnt <= 6;
        end
      end
      if (iocs && prev_iocs) viol <= viol + 1;
      prev_iocs <= iocs;
    end
  end

  task automatic send(input int k, input logic [7:0] b);
    rx_buf[k][rx_wr[k][5:0]] = b;
    rx_wr[k] = rx_wr[k] + 1;
  endtask

  task automatic test_reset;
    int n;
    rst = 1'b1; br_cfg = 2'b01;
    repeat (4) @(negedge clk);
    tests++; if (g_d[0].iocs !== 1'b0) begin fails++; $display("FAIL reset_iocs got %b want 0", g_d[0].iocs); end
    tests++; if (g_d[0].iorw !== 1'b1) begin fails++; $display("FAIL reset_iorw got %b want 1", g_d[0].iorw); end
    tests++; if (g_d[0].echo_busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", g_d[0].echo_busy); end
    tests++; if (g_d[0].line_count !== 8'd0) begin fails++; $display("FAIL reset_lc got %0d want 0", g_d[0].line_count); end
    @(posedge clk); #1 rst = 1'b0;
    for (n = 0; n < 50 && g_d[0].wn < 2; n++) @(negedge clk);
    tests++;
    if (g_d[0].wn < 2) begin fails++; $display("FAIL init_timeout got %0d writes want 2", g_d[0].wn); end
    tests++;
    if (g_d[0].w_addr[0] !== 2'b10 || g_d[0].w_data[0] !== 8'h45) begin
      fails++; $display("FAIL init_lo got %b=%h want 10=45", g_d[0].w_addr[0], g_d[0].w_data[0]);
    end
    tests++;
    if (g_d[0].w_addr[1] !== 2'b11 || g_d[0].w_data[1] !== 8'h01) begin
      fails++; $display("FAIL init_hi got %b=%h want 11=01", g_d[0].w_addr[1], g_d[0].w_data[1]);
    end
  endtask

  task automatic test_cr_line;
    logic [7:0] exp [4] = '{8'h48, 8'h69, 8'h0D, 8'h0A};
    int base = g_d[0].tx_n;
    int idx, n;
    send(0, 8'h48); send(0, 8'h69);
    repeat (40) @(negedge clk);
    tests++; if (g_d[0].tx_n != base) begin fails++; $display("FAIL cr_early_tx got %0d want %0d", g_d[0].tx_n, base); end
    send(0, 8'h0D);
    for (n = 0; n < 600 && g_d[0].line_count != 8'd1; n++) @(negedge clk);
    tests++; if (g_d[0].line_count !== 8'd1) begin fails++; $display("FAIL cr_lc got %0d want 1", g_d[0].line_count); end
    tests++; if (g_d[0].tx_n - base != 4) begin fails++; $display("FAIL cr_len got %0d want 4", g_d[0].tx_n - base); end
    for (int i = 0; i < 4; i++) begin
      idx = base + i;
      tests++;
      if (g_d[0].tx_log[idx[5:0]] !== exp[i]) begin
        fails++; $display("FAIL cr_byte%0d got %h want %h", i, g_d[0].tx_log[idx[5:0]], exp[i]);
      end
    end
    tests++; if (g_d[0].echo_busy !== 1'b0) begin fails++; $display("FAIL cr_busy got %b want 0", g_d[0].echo_busy); end
  endtask

  task automatic test_no_lf;
    logic [7:0] exp [3] = '{8'h6F, 8'h6B, 8'h0D};
    int n;
    send(1, 8'h6F); send(1, 8'h6B); send(1, 8'h0D);
    for (n = 0; n < 600 && g_d[1].line_count != 8'd1; n++) @(negedge clk);
    repeat (30) @(negedge clk);
    tests++; if (g_d[1].line_count !== 8'd1) begin fails++; $display("FAIL nolf_lc got %0d want 1", g_d[1].line_count); end
    tests++; if (g_d[1].tx_n != 3) begin fails++; $display("FAIL nolf_len got %0d want 3", g_d[1].tx_n); end
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (g_d[1].tx_log[i] !== exp[i]) begin
        fails++; $display("FAIL nolf_byte%0d got %h want %h", i, g_d[1].tx_log[i], exp[i]);
      end
    end
  endtask

  task automatic test_full;
    int base = g_d[0].tx_n;
    int idx, n;
    logic [7:0] e;
    for (int i = 0; i < 17; i++) send(0, 8'h61 + 8'(i));
    for (n = 0; n < 2000 && g_d[0].line_count != 8'd2; n++) @(negedge clk);
    repeat (40) @(negedge clk);
    tests++; if (g_d[0].line_count !== 8'd2) begin fails++; $display("FAIL full_lc got %0d want 2", g_d[0].line_count); end
    tests++; if (g_d[0].tx_n - base != 16) begin fails++; $display("FAIL full_len got %0d want 16", g_d[0].tx_n - base); end
    for (int i = 0; i < 16; i++) begin
      idx = base + i; e = 8'h61 + 8'(i);
      tests++;
      if (g_d[0].tx_log[idx[5:0]] !== e) begin
        fails++; $display("FAIL full_byte%0d got %h want %h", i, g_d[0].tx_log[idx[5:0]], e);
      end
    end
    send(0, 8'h0D);
    for (n = 0; n < 600 && g_d[0].line_count != 8'd3; n++) @(negedge clk);
    tests++; if (g_d[0].tx_n - base != 19) begin fails++; $display("FAIL full_next_len got %0d want 19", g_d[0].tx_n - base); end
    idx = base + 16;
    tests++; if (g_d[0].tx_log[idx[5:0]] !== 8'h71) begin fails++; $display("FAIL full_next_q got %h want 71", g_d[0].tx_log[idx[5:0]]); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp [7] = '{8'h41, 8'h42, 8'h0D, 8'h0A, 8'h78, 8'h0D, 8'h0A};
    int base = g_d[0].tx_n;
    int idx, n;
    send(0, 8'h41); send(0, 8'h42); send(0, 8'h0D);
    for (n = 0; n < 300 && g_d[0].echo_busy !== 1'b1; n++) @(negedge clk);
    tests++; if (g_d[0].echo_busy !== 1'b1) begin fails++; $display("FAIL b2b_busy got %b want 1", g_d[0].echo_busy); end
    send(0, 8'h78);
    for (n = 0; n < 600 && g_d[0].line_count != 8'd4; n++) @(negedge clk);
    repeat (30) @(negedge clk);
    tests++; if (g_d[0].tx_n - base != 4) begin fails++; $display("FAIL b2b_len got %0d want 4", g_d[0].tx_n - base); end
    send(0, 8'h0D);
    for (n = 0; n < 600 && g_d[0].line_count != 8'd5; n++) @(negedge clk);
    tests++; if (g_d[0].line_count !== 8'd5) begin fails++; $display("FAIL b2b_lc got %0d want 5", g_d[0].line_count); end
    for (int i = 0; i < 7; i++) begin
      idx = base + i;
      tests++;
      if (g_d[0].tx_log[idx[5:0]] !== exp[i]) begin
        fails++; $display("FAIL b2b_byte%0d got %h want %h", i, g_d[0].tx_log[idx[5:0]], exp[i]);
      end
    end
  endtask

  task automatic test_baud_change;
    int w0 = g_d[0].wn;
    int i1;
    int n;
    br_cfg = 2'b11;
    for (n = 0; n < 50 && g_d[0].wn < w0 + 2; n++) @(negedge clk);
    i1 = w0 + 1;
    tests++;
    if (g_d[0].w_addr[w0[5:0]] !== 2'b10 || g_d[0].w_data[w0[5:0]] !== 8'h51) begin
      fails++; $display("FAIL baud_lo got %b=%h want 10=51", g_d[0].w_addr[w0[5:0]], g_d[0].w_data[w0[5:0]]);
    end
    tests++;
    if (g_d[0].w_addr[i1[5:0]] !== 2'b11 || g_d[0].w_data[i1[5:0]] !== 8'h00) begin
      fails++; $display("FAIL baud_hi got %b=%h want 11=00", g_d[0].w_addr[i1[5:0]], g_d[0].w_data[i1[5:0]]);
    end
  endtask

  task automatic test_reset_mid;
    int w0, i1, n;
    for (int i = 0; i < 5; i++) send(0, 8'h31 + 8'(i));
    send(0, 8'h0D);
    for (n = 0; n < 400 && g_d[0].echo_busy !== 1'b1; n++) @(negedge clk);
    repeat (3) @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    tests++; if (g_d[0].iocs !== 1'b0) begin fails++; $display("FAIL mid_iocs got %b want 0", g_d[0].iocs); end
    @(negedge clk);
    tests++; if (g_d[0].echo_busy !== 1'b0) begin fails++; $display("FAIL mid_busy got %b want 0", g_d[0].echo_busy); end
    tests++; if (g_d[0].line_count !== 8'd0) begin fails++; $display("FAIL mid_lc got %0d want 0", g_d[0].line_count); end
    w0 = g_d[0].wn; i1 = w0 + 1;
    @(posedge clk); #1 rst = 1'b0;
    for (n = 0; n < 50 && g_d[0].wn < w0 + 2; n++) @(negedge clk);
    tests++;
    if (g_d[0].w_addr[w0[5:0]] !== 2'b10 || g_d[0].w_data[w0[5:0]] !== 8'h51) begin
      fails++; $display("FAIL mid_init_lo got %b=%h want 10=51", g_d[0].w_addr[w0[5:0]], g_d[0].w_data[w0[5:0]]);
    end
    tests++;
    if (g_d[0].w_addr[i1[5:0]] !== 2'b11 || g_d[0].w_data[i1[5:0]] !== 8'h00) begin
      fails++; $display("FAIL mid_init_hi got %b=%h want 11=00", g_d[0].w_addr[i1[5:0]], g_d[0].w_data[i1[5:0]]);
    end
  endtask

  task automatic test_protocol;
    tests++; if (g_d[0].viol != 0) begin fails++; $display("FAIL iocs_gap0 got %0d back-to-back want 0", g_d[0].viol); end
    tests++; if (g_d[1].viol != 0) begin fails++; $display("FAIL iocs_gap1 got %0d back-to-back want 0", g_d[1].viol); end
  endtask

  initial begin
    rx_wr[0] = 0; rx_wr[1] = 0;
    test_reset();
    test_cr_line();
    test_no_lf();
    test_full();
    test_back_to_back();
    test_baud_change();
    test_reset_mid();
    test_protocol();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout got no finish want finish");
    $fatal(1);
  end

endmodule
